triangle_setup: RTL and testbench
=================================

// Module: triangle_setup
// PURPOSE
//  Consumes screen-space triangles from the transform pipeline (v0..v2 = {x,y,z}; x,y integer pixels, z unsigned Q0.12).
//  Computes edge-function coefficients, twice-signed area and a screen-clamped bounding box.
//  Culls degenerate, back-facing and off-screen triangles, then hands setup records to the rasterizer over a valid/ready handshake.
//  Its o_ready drives transform_pipeline_next upstream.
// PARAMETERS
//  DATAWIDTH       12   vertex component width (signed x,y; z read as unsigned)
//  SCREEN_WIDTH    320  pixels; bbox x clamped to [0, SCREEN_WIDTH-1]
//  SCREEN_HEIGHT   320  pixels; bbox y clamped to [0, SCREEN_HEIGHT-1]
//  CULL_BACKFACE   1    1: cull area2<0 (CCW front-facing); 0: keep both windings (CW records are negated)
// PORTS
//  clk          in   1               clock
//  rstn         in   1               synchronous active-low reset
//  i_v0/i_v1/i_v2  in  signed [DATAWIDTH-1:0] [3]  triangle vertices {x,y,z}
//  i_triangle_dv   in   1            input triangle valid (one-cycle pulse per triangle)
//  i_triangle_last in   1            qualifies i_triangle_dv: final triangle of model
//  o_ready      out  1               skid buffer empty; may accept more triangles
//  o_edge_a     out  signed [DATAWIDTH:0] [3]     per-edge A = y_i - y_j (edges 01,12,20)
//  o_edge_b     out  signed [DATAWIDTH:0] [3]     per-edge B = x_j - x_i
//  o_edge_c     out  signed [2*DATAWIDTH:0] [3]   per-edge C = x_i*y_j - x_j*y_i
//  o_area2      out  signed [2*DATAWIDTH+2:0]     C01+C12+C20 (>0 after normalisation)
//  o_bb_min     out  [DATAWIDTH-1:0] [2]          clamped {xmin,ymin}
//  o_bb_max     out  [DATAWIDTH-1:0] [2]          clamped {xmax,ymax}
//  o_z          out  [DATAWIDTH-1:0] [3]          pass-through vertex depths
//  o_dv         out  1               output record valid; held until i_ready
//  o_last       out  1               record closes the model
//  o_empty      out  1               record carries no geometry (culled last triangle)
//  i_ready      in   1               rasterizer accepts record when o_dv & i_ready
//  o_overflow   out  1               sticky: triangle arrived with skid full (dropped)
// BEHAVIOUR
//  Reset: all outputs 0 except o_ready=1; FSM IDLE; skid empty; o_overflow cleared only by reset.
//  FSM: IDLE -> EDGE -> AREA -> CULL -> OUT -> (skid full ? EDGE : IDLE).
//   IDLE: i_triangle_dv latches the vertices into the work register -> EDGE.
//   EDGE: register A,B,C for the 3 edges; min/max of x,y.
//   AREA: area2 = sum C; clamp bbox.
//   CULL: cull if area2==0; or area2<0 with CULL_BACKFACE=1; or bbox wholly off-screen (xmax<0, xmin>=W, ymax<0, ymin>=H).
//    Kept, area2<0, CULL_BACKFACE=0: negate A,B,C,area2.
//    Culled, not last: skip OUT; next state chosen as from OUT.
//    Culled, last: emit record with o_empty=1, o_last=1.
//   OUT: o_dv=1, all outputs stable until i_ready; leave OUT on the cycle o_dv&i_ready.
//  Latency: dv accepted at cycle N -> o_dv at N+4 (i_ready=1). Throughput: 1 triangle / 4 cycles.
//  Skid: upstream keeps issuing for a few cycles after o_ready falls.
//   dv while FSM not IDLE -> stored in the 1-entry skid; o_ready=0 while skid full.
//   dv with skid full -> triangle dropped, o_overflow=1.
//   dv arriving on the cycle the skid drains is stored.
//  Arithmetic: signed, full precision, no truncation.
//   Bbox uses signed compares before clamp; clamped values are unsigned.
//   z never enters arithmetic.
//  o_last asserts only on the record derived from an input with i_triangle_last=1.
//  Mid-operation reset: discards work, skid and output; o_dv drops the next cycle.
// STRUCTURE
//  render_pkg: vertex_t {x,y,z}, edge_coeff_t {a,b,c}, setup_state_t enum, screen-size constants.
//  Sub-module triangle_setup_edge: one edge (vi,vj) -> registered {a,b,c}; instantiated x3.
// TESTING
//  CCW (10,10),(50,10),(10,50), z=100,200,300 -> o_dv at N+4; area2=1600; bbox (10,10)-(50,50); A01=0, B01=40, C01=-400.
//  Same triangle CW, CULL_BACKFACE=1 -> no o_dv. With CULL_BACKFACE=0 -> area2=+1600, coefficients negated.
//  Collinear (0,0),(5,5),(10,10), last=1 -> single record, o_dv=o_last=o_empty=1.
//  (-20,-20),(400,-20),(-20,400) -> bbox clamped (0,0)-(319,319).
//  3 back-to-back dv pulses with i_ready=0 -> 1st in OUT, 2nd in skid, 3rd dropped; o_overflow=1.
//  Release i_ready -> exactly 2 records, in order.

Source files
------------

// File: rtl/triangle_setup_pkg.sv
// Shared types and constants for the triangle setup stage.
package triangle_setup_pkg;

  localparam int DATAWIDTH = 12;
  localparam int AREA_W    = 2 * DATAWIDTH + 3;
  localparam int SCREEN_W  = 320;
  localparam int SCREEN_H  = 320;

  // Screen-space vertex: x,y signed integer pixels, z unsigned Q0.12 depth.
  typedef struct packed {
    logic [DATAWIDTH-1:0] x;
    logic [DATAWIDTH-1:0] y;
    logic [DATAWIDTH-1:0] z;
  } vertex_t;

  // Edge function E(x,y) = a*x + b*y + c; all fields two's complement.
  typedef struct packed {
    logic [DATAWIDTH:0]   a;
    logic [DATAWIDTH:0]   b;
    logic [2*DATAWIDTH:0] c;
  } edge_coeff_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_EDGE = 3'd1,
    ST_AREA = 3'd2,
    ST_CULL = 3'd3,
    ST_OUT  = 3'd4
  } setup_state_t;

  // Clamp a signed coordinate into [0, hi]; result is an unsigned pixel index.
  function automatic logic [DATAWIDTH-1:0] clamp_coord(input logic signed [DATAWIDTH-1:0] v,
                                                       input int hi);
    logic [DATAWIDTH-1:0] r;
    if (v[DATAWIDTH-1]) r = '0;
    else if (int'(v) > hi) r = DATAWIDTH'(hi);
    else r = v;
    return r;
  endfunction

endpackage

// File: rtl/triangle_setup_if.sv
// Triangle-in / setup-record-out bus of the triangle setup stage.
//
// Handshakes:
//  - Input side is a pulse protocol: i_triangle_dv is high for one cycle per
//    triangle, i_triangle_last qualifies it. o_ready is advisory (skid empty);
//    a triangle arriving while the skid is full is dropped and o_overflow sets.
//  - Output side is strict valid/ready: once o_dv rises, every record field is
//    held stable until the cycle where o_dv & i_ready are both high, which is
//    the transfer cycle. o_dv never drops without a transfer (except on reset).
interface triangle_setup_if;
  import triangle_setup_pkg::*;

  vertex_t                    i_v0;
  vertex_t                    i_v1;
  vertex_t                    i_v2;
  logic                       i_triangle_dv;
  logic                       i_triangle_last;
  logic                       o_ready;

  logic signed [DATAWIDTH:0]   o_edge_a [3];
  logic signed [DATAWIDTH:0]   o_edge_b [3];
  logic signed [2*DATAWIDTH:0] o_edge_c [3];
  logic signed [AREA_W-1:0]    o_area2;
  logic [DATAWIDTH-1:0]        o_bb_min [2];
  logic [DATAWIDTH-1:0]        o_bb_max [2];
  logic [DATAWIDTH-1:0]        o_z      [3];
  logic                        o_dv;
  logic                        o_last;
  logic                        o_empty;
  logic                        i_ready;
  logic                        o_overflow;

  // Setup stage side.
  modport slave (
    input  i_v0, i_v1, i_v2, i_triangle_dv, i_triangle_last, i_ready,
    output o_ready, o_edge_a, o_edge_b, o_edge_c, o_area2, o_bb_min, o_bb_max,
           o_z, o_dv, o_last, o_empty, o_overflow
  );

  // Environment side: produces triangles, consumes records.
  modport master (
    output i_v0, i_v1, i_v2, i_triangle_dv, i_triangle_last, i_ready,
    input  o_ready, o_edge_a, o_edge_b, o_edge_c, o_area2, o_bb_min, o_bb_max,
           o_z, o_dv, o_last, o_empty, o_overflow
  );
endinterface

// File: rtl/triangle_setup_edge.sv
// One triangle edge (vi -> vj): registers A = yi-yj, B = xj-xi,
// C = xi*yj - xj*yi at full precision when enabled.
module triangle_setup_edge
  import triangle_setup_pkg::*;
(
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic [DATAWIDTH-1:0] xi,
  input  logic [DATAWIDTH-1:0] yi,
  input  logic [DATAWIDTH-1:0] xj,
  input  logic [DATAWIDTH-1:0] yj,
  output edge_coeff_t          coeff
);

  logic [DATAWIDTH:0]     a_d;
  logic [DATAWIDTH:0]     b_d;
  logic [2*DATAWIDTH-1:0] xi_e, yi_e, xj_e, yj_e;
  logic [2*DATAWIDTH-1:0] p_ij, p_ji;
  logic [2*DATAWIDTH:0]   c_d;

  // Sign-extend operands explicitly so every product and difference is exact.
  always_comb begin
    a_d  = {yi[DATAWIDTH-1], yi} - {yj[DATAWIDTH-1], yj};
    b_d  = {xj[DATAWIDTH-1], xj} - {xi[DATAWIDTH-1], xi};
    xi_e = {{DATAWIDTH{xi[DATAWIDTH-1]}}, xi};
    yi_e = {{DATAWIDTH{yi[DATAWIDTH-1]}}, yi};
    xj_e = {{DATAWIDTH{xj[DATAWIDTH-1]}}, xj};
    yj_e = {{DATAWIDTH{yj[DATAWIDTH-1]}}, yj};
    p_ij = xi_e * yj_e;
    p_ji = xj_e * yi_e;
    c_d  = {p_ij[2*DATAWIDTH-1], p_ij} - {p_ji[2*DATAWIDTH-1], p_ji};
  end

  // Capture the coefficients in the EDGE step.
  always_ff @(posedge clk) begin
    if (!rstn) coeff <= '0;
    else if (en) coeff <= '{a: a_d, b: b_d, c: c_d};
  end

endmodule

// File: rtl/triangle_setup.sv
// Triangle setup: edge functions, twice-signed area and clamped bounding box,
// with culling, a one-entry input skid and a valid/ready record output.
module triangle_setup
  import triangle_setup_pkg::*;
#(
  parameter int SCREEN_WIDTH  = SCREEN_W,
  parameter int SCREEN_HEIGHT = SCREEN_H,
  parameter bit CULL_BACKFACE = 1'b1
) (
  input  logic          clk,
  input  logic          rstn,
  triangle_setup_if.slave bus,
  output setup_state_t  dbg_state
);

  setup_state_t state, state_nxt;

  vertex_t     in_v  [3];
  vertex_t     w_v   [3];
  vertex_t     s_v   [3];
  logic        w_last, s_last, s_full, overflow;
  edge_coeff_t coeff [3];

  logic signed [DATAWIDTH-1:0] xs [3];
  logic signed [DATAWIDTH-1:0] ys [3];
  logic signed [DATAWIDTH-1:0] xmin_d, xmax_d, ymin_d, ymax_d;
  logic signed [DATAWIDTH-1:0] xmin, xmax, ymin, ymax;
  logic [AREA_W-1:0]           area_d;
  logic [AREA_W-1:0]           area2;
  logic [DATAWIDTH-1:0]        bb_lo_x, bb_lo_y, bb_hi_x, bb_hi_y;
  logic                        offscreen;

  logic cull, neg, emit, leave, load_in, load_skid, store_skid, drop;

  // Gather the three input vertices for indexed access.
  always_comb begin
    in_v[0] = bus.i_v0;
    in_v[1] = bus.i_v1;
    in_v[2] = bus.i_v2;
  end

  // Cull decision and FSM next-state; 'leave' marks a cycle that frees the work register.
  always_comb begin
    cull      = (area2 == '0) || (CULL_BACKFACE && area2[AREA_W-1]) || offscreen;
    neg       = area2[AREA_W-1];
    emit      = 1'b0;
    leave     = 1'b0;
    state_nxt = state;
    case (state)
      ST_IDLE: if (s_full || bus.i_triangle_dv) state_nxt = ST_EDGE;
      ST_EDGE: state_nxt = ST_AREA;
      ST_AREA: state_nxt = ST_CULL;
      ST_CULL: begin
        if (!cull || w_last) begin
          emit      = 1'b1;
          state_nxt = ST_OUT;
        end else begin
          leave     = 1'b1;
          state_nxt = s_full ? ST_EDGE : ST_IDLE;
        end
      end
      ST_OUT: begin
        if (bus.i_ready) begin
          leave     = 1'b1;
          state_nxt = s_full ? ST_EDGE : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    load_skid  = s_full && ((state == ST_IDLE) || leave);
    load_in    = (state == ST_IDLE) && !s_full && bus.i_triangle_dv;
    store_skid = bus.i_triangle_dv && !load_in && (!s_full || load_skid);
    drop       = bus.i_triangle_dv && !load_in && s_full && !load_skid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Work register: fed straight from the input when idle, otherwise from the skid.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) w_v[k] <= '0;
      w_last <= 1'b0;
    end else if (load_in) begin
      for (int k = 0; k < 3; k++) w_v[k] <= in_v[k];
      w_last <= bus.i_triangle_last;
    end else if (load_skid) begin
      for (int k = 0; k < 3; k++) w_v[k] <= s_v[k];
      w_last <= s_last;
    end
  end

  // One-entry skid; a triangle arriving as the skid drains takes the freed slot.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) s_v[k] <= '0;
      s_last   <= 1'b0;
      s_full   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (store_skid) begin
        for (int k = 0; k < 3; k++) s_v[k] <= in_v[k];
        s_last <= bus.i_triangle_last;
        s_full <= 1'b1;
      end else if (load_skid) begin
        s_full <= 1'b0;
      end
      if (drop) overflow <= 1'b1;
    end
  end

  // Edge coefficient units for edges 01, 12 and 20.
  triangle_setup_edge u_edge01 (
    .clk(clk), .rstn(rstn), .en(state == ST_EDGE),
    .xi(w_v[0].x), .yi(w_v[0].y), .xj(w_v[1].x), .yj(w_v[1].y), .coeff(coeff[0])
  );
  triangle_setup_edge u_edge12 (
    .clk(clk), .rstn(rstn), .en(state == ST_EDGE),
    .xi(w_v[1].x), .yi(w_v[1].y), .xj(w_v[2].x), .yj(w_v[2].y), .coeff(coeff[1])
  );
  triangle_setup_edge u_edge20 (
    .clk(clk), .rstn(rstn), .en(state == ST_EDGE),
    .xi(w_v[2].x), .yi(w_v[2].y), .xj(w_v[0].x), .yj(w_v[0].y), .coeff(coeff[2])
  );

  // Signed extents of the work triangle and the sum of the edge constants.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      xs[k] = $signed(w_v[k].x);
      ys[k] = $signed(w_v[k].y);
    end
    xmin_d = xs[0];
    xmax_d = xs[0];
    ymin_d = ys[0];
    ymax_d = ys[0];
    for (int k = 1; k < 3; k++) begin
      if (xs[k] < xmin_d) xmin_d = xs[k];
      if (xs[k] > xmax_d) xmax_d = xs[k];
      if (ys[k] < ymin_d) ymin_d = ys[k];
      if (ys[k] > ymax_d) ymax_d = ys[k];
    end
    area_d = '0;
    for (int k = 0; k < 3; k++)
      area_d = area_d + {{2{coeff[k].c[2*DATAWIDTH]}}, coeff[k].c};
  end

  // EDGE: raw extents. AREA: area, clamped box and the off-screen test.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      xmin <= '0; xmax <= '0; ymin <= '0; ymax <= '0;
      area2 <= '0;
      bb_lo_x <= '0; bb_lo_y <= '0; bb_hi_x <= '0; bb_hi_y <= '0;
      offscreen <= 1'b0;
    end else if (state == ST_EDGE) begin
      xmin <= xmin_d; xmax <= xmax_d; ymin <= ymin_d; ymax <= ymax_d;
    end else if (state == ST_AREA) begin
      area2     <= area_d;
      bb_lo_x   <= clamp_coord(xmin, SCREEN_WIDTH - 1);
      bb_lo_y   <= clamp_coord(ymin, SCREEN_HEIGHT - 1);
      bb_hi_x   <= clamp_coord(xmax, SCREEN_WIDTH - 1);
      bb_hi_y   <= clamp_coord(ymax, SCREEN_HEIGHT - 1);
      offscreen <= (xmax < 0) || (int'(xmin) >= SCREEN_WIDTH) ||
                   (ymax < 0) || (int'(ymin) >= SCREEN_HEIGHT);
    end
  end

  // Record register: loaded once per emitted record, normalised to positive area;
  // a culled last triangle becomes an empty record.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < 3; k++) begin
        bus.o_edge_a[k] <= '0;
        bus.o_edge_b[k] <= '0;
        bus.o_edge_c[k] <= '0;
        bus.o_z[k]      <= '0;
      end
      for (int k = 0; k < 2; k++) begin
        bus.o_bb_min[k] <= '0;
        bus.o_bb_max[k] <= '0;
      end
      bus.o_area2 <= '0;
      bus.o_last  <= 1'b0;
      bus.o_empty <= 1'b0;
    end else if (emit) begin
      for (int k = 0; k < 3; k++) begin
        if (cull) begin
          bus.o_edge_a[k] <= '0;
          bus.o_edge_b[k] <= '0;
          bus.o_edge_c[k] <= '0;
          bus.o_z[k]      <= '0;
        end else begin
          bus.o_edge_a[k] <= neg ? ('0 - coeff[k].a) : coeff[k].a;
          bus.o_edge_b[k] <= neg ? ('0 - coeff[k].b) : coeff[k].b;
          bus.o_edge_c[k] <= neg ? ('0 - coeff[k].c) : coeff[k].c;
          bus.o_z[k]      <= w_v[k].z;
        end
      end
      bus.o_area2     <= cull ? '0 : (neg ? ('0 - area2) : area2);
      bus.o_bb_min[0] <= cull ? '0 : bb_lo_x;
      bus.o_bb_min[1] <= cull ? '0 : bb_lo_y;
      bus.o_bb_max[0] <= cull ? '0 : bb_hi_x;
      bus.o_bb_max[1] <= cull ? '0 : bb_hi_y;
      bus.o_last      <= w_last;
      bus.o_empty     <= cull;
    end
  end

  assign bus.o_dv       = (state == ST_OUT);
  assign bus.o_ready    = !s_full;
  assign bus.o_overflow = overflow;
  assign dbg_state      = state;

endmodule

// File: tb/tb_triangle_setup.sv
// Directed bench for triangle_setup: one instance culls back faces, the other
// keeps both windings; both see identical stimulus.
module tb_triangle_setup;
  import triangle_setup_pkg::*;

  logic         clk = 1'b0;
  logic         rstn;
  setup_state_t st_a, st_b;

  triangle_setup_if ifa ();
  triangle_setup_if ifb ();

  triangle_setup #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(320), .CULL_BACKFACE(1'b1)) dut_a (
    .clk(clk), .rstn(rstn), .bus(ifa), .dbg_state(st_a)
  );
  triangle_setup #(.SCREEN_WIDTH(320), .SCREEN_HEIGHT(320), .CULL_BACKFACE(1'b0)) dut_b (
    .clk(clk), .rstn(rstn), .bus(ifb), .dbg_state(st_b)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000ns");
    $fatal(1, "watchdog expired");
  end

  int n_cmp  = 0;
  int n_fail = 0;
  logic [AREA_W-1:0] exp_q [$];
  logic [AREA_W-1:0] got_q [$];

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_tri(input int x0, input int y0, input int z0,
                         input int x1, input int y1, input int z1,
                         input int x2, input int y2, input int z2,
                         input logic last);
    vertex_t a, b, c;
    a = '{x: 12'(x0), y: 12'(y0), z: 12'(z0)};
    b = '{x: 12'(x1), y: 12'(y1), z: 12'(z1)};
    c = '{x: 12'(x2), y: 12'(y2), z: 12'(z2)};
    ifa.i_v0 = a; ifa.i_v1 = b; ifa.i_v2 = c; ifa.i_triangle_last = last;
    ifb.i_v0 = a; ifb.i_v1 = b; ifb.i_v2 = c; ifb.i_triangle_last = last;
  endtask

  task automatic set_dv(input logic v);
    ifa.i_triangle_dv = v;
    ifb.i_triangle_dv = v;
  endtask

  task automatic set_ready(input logic v);
    ifa.i_ready = v;
    ifb.i_ready = v;
  endtask

  // One-cycle dv pulse; returns just after the sampling edge.
  task automatic send_tri(input int x0, input int y0, input int z0,
                          input int x1, input int y1, input int z1,
                          input int x2, input int y2, input int z2,
                          input logic last);
    @(posedge clk); #1;
    set_tri(x0, y0, z0, x1, y1, z1, x2, y2, z2, last);
    set_dv(1'b1);
    @(posedge clk); #1;
    set_dv(1'b0);
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
  endtask

  // Counts falling edges until instance A shows o_dv; -1 if none within budget.
  task automatic wait_dv_a(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (ifa.o_dv) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat, a_seen, b_lat;

  initial begin
    // Reset.
    rstn = 1'b0;
    set_dv(1'b0);
    set_ready(1'b1);
    set_tri(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_dv", ifa.o_dv, 0);
    check("rst_ready", ifa.o_ready, 1);
    check("rst_overflow", ifa.o_overflow, 0);
    check("rst_area2", ifa.o_area2, 0);
    check("rst_state", st_a, ST_IDLE);
    rstn = 1'b1;

    // CCW triangle: latency and full record.
    send_tri(10, 10, 100, 50, 10, 200, 10, 50, 300, 1'b0);
    wait_dv_a(lat);
    check("ccw_latency", lat, 4);
    check("ccw_area2", ifa.o_area2, 1600);
    check("ccw_a01", ifa.o_edge_a[0], 0);
    check("ccw_b01", ifa.o_edge_b[0], 40);
    check("ccw_c01", ifa.o_edge_c[0], -400);
    check("ccw_a12", ifa.o_edge_a[1], -40);
    check("ccw_c12", ifa.o_edge_c[1], 2400);
    check("ccw_a20", ifa.o_edge_a[2], 40);
    check("ccw_bbmin_x", ifa.o_bb_min[0], 10);
    check("ccw_bbmin_y", ifa.o_bb_min[1], 10);
    check("ccw_bbmax_x", ifa.o_bb_max[0], 50);
    check("ccw_bbmax_y", ifa.o_bb_max[1], 50);
    check("ccw_z1", ifa.o_z[1], 200);
    check("ccw_z2", ifa.o_z[2], 300);
    check("ccw_last", ifa.o_last, 0);
    check("ccw_empty", ifa.o_empty, 0);

    // CW triangle: culled on A, negated record on B.
    send_tri(10, 10, 100, 10, 50, 200, 50, 10, 300, 1'b0);
    a_seen = 0;
    b_lat  = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (ifa.o_dv) a_seen++;
      if (ifb.o_dv && b_lat < 0) b_lat = i;
    end
    check("cw_cull_dv_count", a_seen, 0);
    check("cw_cull_state", st_a, ST_IDLE);
    check("cw_keep_latency", b_lat, 4);
    check("cw_keep_area2", ifb.o_area2, 1600);
    check("cw_keep_a01", ifb.o_edge_a[0], 40);
    check("cw_keep_b12", ifb.o_edge_b[1], -40);
    check("cw_keep_c12", ifb.o_edge_c[1], 2400);
    check("cw_keep_c20", ifb.o_edge_c[2], -400);

    // Collinear last triangle: a single empty record.
    send_tri(0, 0, 7, 5, 5, 8, 10, 10, 9, 1'b1);
    wait_dv_a(lat);
    check("deg_latency", lat, 4);
    check("deg_last", ifa.o_last, 1);
    check("deg_empty", ifa.o_empty, 1);
    check("deg_area2", ifa.o_area2, 0);
    check("deg_z0", ifa.o_z[0], 0);
    a_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.o_dv) a_seen++;
    end
    check("deg_extra_records", a_seen, 0);

    // Partly off-screen triangle: box clamped to the screen.
    send_tri(-20, -20, 1, 400, -20, 2, -20, 400, 3, 1'b0);
    wait_dv_a(lat);
    check("clamp_latency", lat, 4);
    check("clamp_area2", ifa.o_area2, 176400);
    check("clamp_b01", ifa.o_edge_b[0], 420);
    check("clamp_c12", ifa.o_edge_c[1], 159600);
    check("clamp_bbmin_x", ifa.o_bb_min[0], 0);
    check("clamp_bbmin_y", ifa.o_bb_min[1], 0);
    check("clamp_bbmax_x", ifa.o_bb_max[0], 319);
    check("clamp_bbmax_y", ifa.o_bb_max[1], 319);

    // Wholly off-screen (xmin >= width), positive area: culled.
    send_tri(400, 10, 1, 500, 10, 2, 400, 60, 3, 1'b0);
    a_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifa.o_dv) a_seen++;
    end
    check("offscreen_dv_count", a_seen, 0);

    // Three back-to-back triangles with the rasterizer stalled.
    check("pre_overflow", ifa.o_overflow, 0);
    set_ready(1'b0);
    @(posedge clk); #1;
    set_tri(10, 10, 100, 50, 10, 200, 10, 50, 300, 1'b0);
    set_dv(1'b1);
    @(posedge clk); #1;
    set_tri(-20, -20, 1, 400, -20, 2, -20, 400, 3, 1'b0);
    @(posedge clk); #1;
    set_tri(10, 10, 4, 20, 10, 5, 10, 20, 6, 1'b0);
    @(posedge clk); #1;
    set_dv(1'b0);
    check("burst_ready", ifa.o_ready, 0);
    check("burst_overflow", ifa.o_overflow, 1);
    exp_q.push_back(AREA_W'(1600));
    exp_q.push_back(AREA_W'(176400));
    wait_dv_a(lat);
    check("stall_dv_seen", (lat > 0), 1);
    repeat (3) @(negedge clk);
    check("stall_dv_held", ifa.o_dv, 1);
    check("stall_area2_held", ifa.o_area2, 1600);
    set_ready(1'b1);
    for (int i = 0; i < 20; i++) begin
      if (ifa.o_dv) got_q.push_back(ifa.o_area2);
      @(negedge clk);
    end
    check("drain_count", got_q.size(), 2);
    for (int i = 0; i < exp_q.size(); i++)
      check("drain_area2", (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    check("drain_ready", ifa.o_ready, 1);
    check("overflow_sticky", ifa.o_overflow, 1);

    // Reset in the middle of a triangle.
    send_tri(10, 10, 100, 50, 10, 200, 10, 50, 300, 1'b0);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("midrst_dv", ifa.o_dv, 0);
    check("midrst_state", st_a, ST_IDLE);
    check("midrst_overflow", ifa.o_overflow, 0);
    check("midrst_area2", ifa.o_area2, 0);
    rstn = 1'b1;
    send_tri(10, 10, 100, 50, 10, 200, 10, 50, 300, 1'b1);
    wait_dv_a(lat);
    check("post_rst_latency", lat, 4);
    check("post_rst_area2", ifa.o_area2, 1600);
    check("post_rst_last", ifa.o_last, 1);
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
